// File: rtl/ieee754_pkg.sv
// Shared IEEE-754 single-precision field definitions, FSM states and input classes
// for the float-to-fixed converter.
package ieee754_pkg;

    localparam int unsigned EXP_BIAS = 127;
    localparam int unsigned EXP_W    = 8;
    localparam int unsigned MAN_W    = 23;
    localparam logic [7:0]  EXP_SPECIAL = 8'hFF;
    // Shift distances never exceed 40 (int_len+fra_len-24) or 23, so 7 bits is ample.
    localparam int unsigned CNT_W    = 7;

    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic [MAN_W-1:0] man;
    } ieee_single_t;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_e;

    typedef enum logic [2:0] {
        CLS_ZERO,
        CLS_SPECIAL,
        CLS_OVF,
        CLS_UNF,
        CLS_NORMAL
    } class_e;

endpackage

// File: rtl/ieee_classify.sv
// Combinational decode of an IEEE-754 single into a conversion class, plus the
// alignment shift distance and direction for the normal class.
module ieee_classify
    import ieee754_pkg::*;
#(
    parameter int unsigned int_len = 16,
    parameter int unsigned fra_len = 16
) (
    input  ieee_single_t     ieee_i,
    output class_e           cls_o,
    output logic [CNT_W-1:0] cnt_o,
    output logic             left_o
);

    localparam int unsigned SW = 10;

    logic signed [SW-1:0] e_c;
    logic signed [SW-1:0] s_c;
    logic signed [SW-1:0] abs_c;

    // e is the unbiased exponent; s is the shift that puts the hidden 1 at weight 2^e.
    always_comb begin
        e_c    = $signed({2'b00, ieee_i.exp}) - $signed(SW'(EXP_BIAS));
        s_c    = e_c - $signed(SW'(MAN_W)) + $signed(SW'(fra_len));
        abs_c  = s_c[SW-1] ? -s_c : s_c;
        left_o = ~s_c[SW-1];
        cnt_o  = CNT_W'(abs_c);

        if (ieee_i.exp == '0) begin
            cls_o = CLS_ZERO;
        end else if (ieee_i.exp == EXP_SPECIAL) begin
            cls_o = CLS_SPECIAL;
        end else if (e_c >= $signed(SW'(int_len))) begin
            cls_o = CLS_OVF;
        end else if (e_c < -$signed(SW'(fra_len))) begin
            cls_o = CLS_UNF;
        end else begin
            cls_o = CLS_NORMAL;
        end
    end

endmodule

// File: rtl/ieee_to_fixed_converter.sv
// IEEE-754 single to unsigned fixed-point magnitude plus sign, aligned by a
// 1-bit-per-cycle shifter behind valid/ready handshakes.
module ieee_to_fixed_converter
    import ieee754_pkg::*;
#(
    parameter int unsigned int_len = 16,
    parameter int unsigned fra_len = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [31:0]        ieee_val,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [int_len-1:0] o_integer,
    output logic [fra_len-1:0] o_fraction,
    output logic               sign_flag,
    output logic               overflow,
    output logic               inexact,
    output logic               nan_flag
);

    localparam int unsigned OW = int_len + fra_len;
    localparam int unsigned WW = (OW > 24) ? OW : 24;

    ieee_single_t     in_c;
    class_e           cls_c;
    logic [CNT_W-1:0] cls_cnt_c;
    logic             cls_left_c;

    assign in_c = ieee_single_t'(ieee_val);

    ieee_classify #(
        .int_len (int_len),
        .fra_len (fra_len)
    ) u_classify (
        .ieee_i (in_c),
        .cls_o  (cls_c),
        .cnt_o  (cls_cnt_c),
        .left_o (cls_left_c)
    );

    state_e           state_q, state_d;
    logic [WW-1:0]    w_q, w_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             left_q, left_d;
    logic             sticky_q, sticky_d;
    logic             sign_q, sign_d;
    logic [OW-1:0]    res_q, res_d;
    logic             sgn_out_q, sgn_out_d;
    logic             ovf_q, ovf_d;
    logic             inx_q, inx_d;
    logic             nan_q, nan_d;
    logic             in_ready_q, out_valid_q;

    logic [OW-1:0]    nres_c;
    logic             novf_c, ninx_c, nnan_c, use_w_c;

    always_comb begin
        state_d   = state_q;
        w_d       = w_q;
        cnt_d     = cnt_q;
        left_d    = left_q;
        sticky_d  = sticky_q;
        sign_d    = sign_q;
        res_d     = res_q;
        sgn_out_d = sgn_out_q;
        ovf_d     = ovf_q;
        inx_d     = inx_q;
        nan_d     = nan_q;
        nres_c    = '0;
        novf_c    = 1'b0;
        ninx_c    = 1'b0;
        nnan_c    = 1'b0;
        use_w_c   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    sign_d  = in_c.sign;
                    state_d = DONE;
                    unique case (cls_c)
                        CLS_ZERO: ninx_c = |in_c.man;
                        CLS_SPECIAL: begin
                            nres_c = '1;
                            novf_c = 1'b1;
                            nnan_c = |in_c.man;
                        end
                        CLS_OVF: begin
                            nres_c = '1;
                            novf_c = 1'b1;
                        end
                        CLS_UNF: ninx_c = 1'b1;
                        default: begin
                            w_d      = WW'({1'b1, in_c.man});
                            cnt_d    = cls_cnt_c;
                            left_d   = cls_left_c;
                            sticky_d = 1'b0;
                            use_w_c  = 1'b1;
                            if (cls_cnt_c != '0) begin
                                state_d = SHIFT;
                            end
                        end
                    endcase
                end
            end
            SHIFT: begin
                // Right shifts fold the dropped bit into the sticky inexact flag.
                w_d      = left_q ? {w_q[WW-2:0], 1'b0} : {1'b0, w_q[WW-1:1]};
                sticky_d = left_q ? sticky_q : (sticky_q | w_q[0]);
                cnt_d    = cnt_q - CNT_W'(1);
                use_w_c  = 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (use_w_c) begin
            nres_c = w_d[OW-1:0];
            ninx_c = sticky_d;
        end

        // Result registers change only on the edge that enters DONE.
        if (state_q != DONE && state_d == DONE) begin
            res_d     = nres_c;
            sgn_out_d = sign_d;
            ovf_d     = novf_c;
            inx_d     = ninx_c;
            nan_d     = nnan_c;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            w_q         <= '0;
            cnt_q       <= '0;
            left_q      <= 1'b0;
            sticky_q    <= 1'b0;
            sign_q      <= 1'b0;
            res_q       <= '0;
            sgn_out_q   <= 1'b0;
            ovf_q       <= 1'b0;
            inx_q       <= 1'b0;
            nan_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            w_q         <= w_d;
            cnt_q       <= cnt_d;
            left_q      <= left_d;
            sticky_q    <= sticky_d;
            sign_q      <= sign_d;
            res_q       <= res_d;
            sgn_out_q   <= sgn_out_d;
            ovf_q       <= ovf_d;
            inx_q       <= inx_d;
            nan_q       <= nan_d;
            in_ready_q  <= (state_d == IDLE);
            out_valid_q <= (state_d == DONE);
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign o_integer = res_q[OW-1:fra_len];
    assign sign_flag = sgn_out_q;
    assign overflow  = ovf_q;
    assign inexact   = inx_q;
    assign nan_flag  = nan_q;

    generate
        if (fra_len > 0) begin : g_frac
            assign o_fraction = res_q[fra_len-1:0];
        end else begin : g_no_frac
            assign o_fraction = '0;
        end
    endgenerate

endmodule

// File: tb/tb_ieee_to_fixed_converter.sv
// Scoreboard bench for ieee_to_fixed_converter: directed and random floats are
// checked against an arithmetic reference model, including latency and handshakes.
module tb_ieee_to_fixed_converter;

    localparam int IL = 16;
    localparam int FL = 16;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [31:0]   ieee_val;
    logic          out_valid;
    logic          out_ready;
    logic [IL-1:0] o_integer;
    logic [FL-1:0] o_fraction;
    logic          sign_flag;
    logic          overflow;
    logic          inexact;
    logic          nan_flag;

    ieee_to_fixed_converter #(
        .int_len (IL),
        .fra_len (FL)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .ieee_val   (ieee_val),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .o_integer  (o_integer),
        .o_fraction (o_fraction),
        .sign_flag  (sign_flag),
        .overflow   (overflow),
        .inexact    (inexact),
        .nan_flag   (nan_flag)
    );

    typedef struct {
        logic [31:0] in;
        logic [31:0] res;
        logic        sign;
        logic        ovf;
        logic        inx;
        logic        nan;
        int          lat;
        int          acc;
    } exp_t;

    exp_t sb[$];
    exp_t cur;
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   hold_n = 0;
    bit   seen  = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Value = 1.man * 2^(exp-127), scaled by 2^FL and truncated; saturate above 2^(IL+FL).
    function automatic exp_t model(input logic [31:0] v);
        exp_t         r;
        logic [7:0]   ex;
        logic [22:0]  man;
        logic [127:0] mant;
        logic [127:0] big;
        int           s;
        ex     = v[30:23];
        man    = v[22:0];
        r.in   = v;
        r.sign = v[31];
        r.res  = '0;
        r.ovf  = 1'b0;
        r.inx  = 1'b0;
        r.nan  = 1'b0;
        r.lat  = 0;
        r.acc  = 0;
        mant   = 128'({1'b1, man});
        if (ex == 8'd0) begin
            r.inx = (man != 23'd0);
        end else if (ex == 8'hFF) begin
            r.res = '1;
            r.ovf = 1'b1;
            r.nan = (man != 23'd0);
        end else begin
            s = int'(ex) - 150 + FL;
            if (s >= 0) begin
                big = (s > 100) ? '1 : (mant << s);
                if (big[127:IL+FL] != '0) begin
                    r.res = '1;
                    r.ovf = 1'b1;
                end else begin
                    r.res = big[31:0];
                    r.lat = s;
                end
            end else if (-s >= 24) begin
                r.inx = 1'b1;
            end else begin
                r.res = 32'(mant >> (-s));
                r.inx = ((mant & ((128'd1 << (-s)) - 128'd1)) != '0);
                r.lat = -s;
            end
        end
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] in, input logic [63:0] act,
                       input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: in=%08h actual=%0h required=%0h", name, in, act, req);
        end
    endtask

    // Monitor: compares the head of the scoreboard every cycle out_valid is high.
    always @(negedge clk) begin
        if (rst) begin
            seen = 0;
        end else if (out_valid) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_output: actual=%04h_%04h required=none",
                         o_integer, o_fraction);
            end else begin
                cur = sb[0];
                if (!seen) begin
                    chk("latency", cur.in, 64'(cyc), 64'(cur.acc + cur.lat));
                    seen = 1;
                end
                chk("magnitude", cur.in, 64'({o_integer, o_fraction}), 64'(cur.res));
                chk("sign_flag", cur.in, 64'(sign_flag), 64'(cur.sign));
                chk("overflow", cur.in, 64'(overflow), 64'(cur.ovf));
                chk("inexact", cur.in, 64'(inexact), 64'(cur.inx));
                chk("nan_flag", cur.in, 64'(nan_flag), 64'(cur.nan));
                chk("in_ready_busy", cur.in, 64'(in_ready), 64'(0));
            end
            if (hold_n > 0) begin
                out_ready = 1'b0;
                hold_n--;
            end else begin
                out_ready = (($urandom % 3) != 0);
            end
            if (out_ready && sb.size() > 0) begin
                void'(sb.pop_front());
                seen = 0;
            end
        end else begin
            out_ready = 1'(($urandom % 2));
        end
    end

    task automatic send(input logic [31:0] v);
        int   k;
        exp_t e;
        k = 0;
        @(negedge clk);
        in_valid = 1'b1;
        ieee_val = v;
        while (!in_ready && k < 300) begin
            @(negedge clk);
            k++;
        end
        if (!in_ready) begin
            total++;
            bad++;
            $display("FAIL accept_timeout: in=%08h actual=busy required=ready", v);
            in_valid = 1'b0;
        end else begin
            e     = model(v);
            e.acc = cyc + 1;
            sb.push_back(e);
            @(negedge clk);
            in_valid = 1'b0;
            ieee_val = $urandom;
        end
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while (!(sb.size() == 0 && in_ready) && k < 300) begin
            @(negedge clk);
            k++;
        end
        if (k >= 300) begin
            total++;
            bad++;
            $display("FAIL drain_timeout: actual=%0d pending required=0", sb.size());
        end
    endtask

    task automatic chk_cleared(input string tag);
        chk({tag, "_in_ready"}, 32'd0, 64'(in_ready), 64'(1));
        chk({tag, "_out_valid"}, 32'd0, 64'(out_valid), 64'(0));
        chk({tag, "_magnitude"}, 32'd0, 64'({o_integer, o_fraction}), 64'(0));
        chk({tag, "_flags"}, 32'd0, 64'({sign_flag, overflow, inexact, nan_flag}), 64'(0));
    endtask

    logic [31:0] directed [13] = '{
        32'h3FC00000, 32'hC2F60000, 32'h44800000, 32'h3DCCCCCD,
        32'h47800000, 32'h7FC00000, 32'h80000000, 32'h00000001,
        32'h477FFF00, 32'h37800000, 32'h377FFFFF, 32'hFF800000,
        32'h43060000
    };

    initial begin
        logic [7:0] ex;
        int         r;
        rst       = 1'b1;
        in_valid  = 1'b0;
        ieee_val  = '0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk_cleared("reset");
        rst = 1'b0;

        foreach (directed[i]) begin
            send(directed[i]);
            repeat ($urandom % 3) @(negedge clk);
        end
        wait_idle();

        // Backpressure: result must hold for several cycles while a new input waits.
        hold_n = 5;
        send(32'h3FC00000);
        send(32'h44800000);
        wait_idle();

        // Reset mid-shift aborts the 0.1 conversion; previous outputs carry sign=1.
        send(32'hC2F60000);
        wait_idle();
        send(32'h3DCCCCCD);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        #1;
        chk_cleared("abort");
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        send(32'h3FC00000);
        wait_idle();

        for (int n = 0; n < 300; n++) begin
            r = int'($urandom % 10);
            if (r == 0)      ex = 8'd0;
            else if (r == 1) ex = 8'hFF;
            else if (r == 2) ex = 8'($urandom);
            else             ex = 8'(100 + ($urandom % 45));
            send({1'($urandom), ex, (($urandom % 4) == 0) ? 23'd0 : 23'($urandom)});
            repeat ($urandom % 3) @(negedge clk);
        end
        wait_idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/ieee_to_fixed_converter.md
Name: ieee_to_fixed_converter

Overview:
Inverse of the fixed-point-to-IEEE-754 converter. Accepts one IEEE-754 single-precision word and returns an unsigned fixed-point magnitude (int_len integer bits, fra_len fraction bits) plus a separate sign flag. Alignment uses an iterative 1-bit-per-cycle shifter, so area stays small at the cost of latency. Valid/ready handshakes on both sides; sits between float-producing blocks and fixed-point datapaths.

Parameters:
int_len, 16, integer bits of output magnitude; legal range 1..64.
fra_len, 16, fraction bits of output magnitude; legal range 0..64; int_len+fra_len <= 64.

Ports:
clk  input  1  single clock, rising edge.
rst  input  1  asynchronous, active-high reset.
in_valid  input  1  ieee_val is presented.
in_ready  output  1  block can accept; high only in IDLE.
ieee_val  input  32  IEEE-754 single: {sign, exp[7:0], mantissa[22:0]}.
out_valid  output  1  result registers are valid; high only in DONE.
out_ready  input  1  downstream accepts the result.
o_integer  output  int_len  integer part of the magnitude.
o_fraction  output  fra_len  fraction part of the magnitude.
sign_flag  output  1  copy of ieee_val[31]. Passed through for every class, including zero and NaN.
overflow  output  1  magnitude saturated to all ones.
inexact  output  1  nonzero bits were discarded by truncation or underflow.
nan_flag  output  1  input was NaN.

Behaviour:
- Reset: async. State becomes IDLE. in_ready=1 after reset. out_valid, o_integer, o_fraction, sign_flag, overflow, inexact and nan_flag all =0.
- Reset mid-SHIFT or mid-DONE aborts the operation. No output is produced for that operation.
- States: IDLE -> (SHIFT | DONE) -> DONE -> IDLE.
- Accept: on the edge with in_valid&in_ready, latch sign and classify. Let e = exp-127 and s = exp-150+fra_len.
  - exp==0 (zero or denormal; denormals are flushed): result 0. inexact = (mantissa!=0). Go to DONE.
  - exp==255: overflow=1 and result all ones. If mantissa!=0, nan_flag=1. Go to DONE.
  - e >= int_len: overflow=1 and result all ones. Go to DONE.
  - e < -fra_len: result 0 and inexact=1. Go to DONE.
  - Otherwise: load work register W = {1,mantissa} zero-extended to width max(24, int_len+fra_len). Load count = |s| and direction = sign of s. Go to SHIFT if |s|>0, else DONE.
- In the normal case, s lies in [-23, int_len+fra_len-24], so all shifts are bounded.
- SHIFT: each cycle shift W by 1 bit (left if s>0, right if s<0) and decrement count.
  - On a right shift, the bit shifted out is OR-ed into the sticky inexact flag.
  - When count reaches 0, the block enters DONE on the same edge as the final shift.
- Latency: DONE is entered at accept edge + n, where n = |s| for the normal case and n = 0 for special cases. out_valid is visible in the cycle after that edge.
- DONE: out_valid=1. {o_integer,o_fraction} = W[int_len+fra_len-1:0]. All outputs stay stable until the edge with out_ready=1, then the block returns to IDLE.
- out_ready high while the block is not in DONE is ignored.
- in_valid while busy is ignored; the upstream holds data until in_ready.
- Rounding is truncation toward zero on the magnitude; no rounding modes.
- Output registers update only when entering DONE.
- No back-to-back overlap: a new accept occurs at the earliest one cycle after the DONE handshake (IDLE is a visible cycle).

Decomposition:
- Shared package ieee754_pkg holds:
  - localparams EXP_BIAS=127, EXP_W=8, MAN_W=23, EXP_SPECIAL=8'hFF.
  - typedef ieee_single_t as a packed struct {sign, exp, man}.
  - the state enum {IDLE, SHIFT, DONE}.
- One natural sub-module, ieee_classify: a combinational decode of the input into class (zero/special/overflow/underflow/normal), shift count and direction. The FSM and shifter stay in the top module.

Test Plan:
Use int_len=16, fra_len=16 unless noted.
- 0x3FC00000 (1.5) -> 7 right shifts; o_integer=0x0001, o_fraction=0x8000, inexact=0, sign_flag=0, out_valid 7 edges after accept.
- 0xC2F60000 (-123.0) -> 1 right shift; o_integer=0x007B, o_fraction=0x0000, sign_flag=1, inexact=0.
- 0x44800000 (1024.0) -> 3 left shifts; o_integer=0x0400, o_fraction=0x0000.
- 0x3DCCCCCD (0.1) -> 11 right shifts; o_integer=0x0000, o_fraction=0x1999, inexact=1.
- Special cases, each with out_valid 1 cycle after accept:
  - 0x47800000 (65536.0) -> overflow=1, o_integer=0xFFFF, o_fraction=0xFFFF.
  - 0x7FC00000 -> nan_flag=1, overflow=1, saturated.
  - 0x80000000 -> zero result, sign_flag=1, inexact=0.
  - 0x00000001 -> zero, inexact=1.
- Handshake and reset:
  - Hold out_ready=0 for 5 cycles in DONE -> outputs stable, in_ready=0, in_valid ignored.
  - Assert rst during SHIFT of the 0.1 case -> immediate IDLE with all outputs 0. The next 1.5 input converts correctly.
